// File: rtl/door_tally.sv
// door_tally: tallies door selections over a frame of FRAME valid beats,
// then reports one word per door (0..4) through a valid/ready port.
// A frame that completes while a report is still in progress sets a sticky overrun flag.
module door_tally #(
  parameter int FRAME = 16
) (
  input  logic       clk2,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [2:0] out_door,
  output logic [7:0] out_count,
  output logic [4:0] out_id,
  output logic       out_last,
  output logic       overrun,
  output logic [7:0] bad_cnt
);

  typedef enum logic {IDLE, REPORT} state_e;

  localparam logic [7:0] LAST_BEAT = 8'(FRAME - 1);
  localparam logic [2:0] LAST_K    = 3'd4;

  state_e          state_q, state_d;
  logic [2:0]      k_q, k_d;
  logic [4:0][7:0] cnt_q, cnt_d, snap_cnt_q, snap_cnt_d, live_cnt;
  logic [4:0][4:0] id_q, id_d, snap_id_q, snap_id_d, live_id;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic [7:0]      bad_cnt_q, bad_cnt_d;
  logic            overrun_q, overrun_d;
  logic            out_valid_q, out_valid_d;
  logic [2:0]      out_door_q, out_door_d;
  logic [7:0]      out_count_q, out_count_d;
  logic [4:0]      out_id_q, out_id_d;
  logic            out_last_q, out_last_d;

  logic [2:0] door;
  logic [4:0] id;
  logic       beat, bad, frame_done, hs, last_hs, capture;

  // Next-state: live tally, snapshot capture, report sequencing and output word.
  always_comb begin
    door       = in_data[7:5];
    id         = in_data[4:0];
    beat       = in_valid && (door < 3'd5);
    bad        = in_valid && (door >= 3'd5);
    frame_done = beat && (frame_cnt_q == LAST_BEAT);
    hs         = out_valid_q && out_ready;
    last_hs    = (state_q == REPORT) && hs && (k_q == LAST_K);
    // A new snapshot is only taken when no report words remain after this edge.
    capture    = frame_done && ((state_q == IDLE) || last_hs);

    // Live state including the current beat; this is what a capture sees.
    live_cnt = cnt_q;
    live_id  = id_q;
    if (beat) begin
      live_cnt[door] = cnt_q[door] + 8'd1;
      live_id[door]  = id;
    end

    cnt_d       = frame_done ? '0 : live_cnt;
    id_d        = frame_done ? '0 : live_id;
    frame_cnt_d = frame_done ? 8'd0 : (beat ? frame_cnt_q + 8'd1 : frame_cnt_q);
    bad_cnt_d   = (bad && (bad_cnt_q != 8'hFF)) ? bad_cnt_q + 8'd1 : bad_cnt_q;

    state_d    = state_q;
    k_d        = k_q;
    snap_cnt_d = snap_cnt_q;
    snap_id_d  = snap_id_q;
    overrun_d  = overrun_q;

    if ((state_q == REPORT) && hs) begin
      if (k_q == LAST_K) begin
        state_d = IDLE;
        k_d     = 3'd0;
      end else begin
        k_d = k_q + 3'd1;
      end
    end

    if (capture) begin
      state_d    = REPORT;
      k_d        = 3'd0;
      snap_cnt_d = live_cnt;
      snap_id_d  = live_id;
    end else if (frame_done) begin
      overrun_d = 1'b1;
    end

    // Output word is registered, derived from the next state so it lines up with k.
    out_valid_d = (state_d == REPORT);
    out_door_d  = 3'd0;
    out_count_d = 8'd0;
    out_id_d    = 5'd0;
    out_last_d  = 1'b0;
    if ((state_d == REPORT) && (k_d <= LAST_K)) begin
      out_door_d  = k_d;
      out_count_d = snap_cnt_d[k_d];
      out_id_d    = snap_id_d[k_d];
      out_last_d  = (k_d == LAST_K);
    end
  end

  // State registers; synchronous reset drops any beat arriving with it.
  always_ff @(posedge clk2) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= 3'd0;
      cnt_q       <= '0;
      id_q        <= '0;
      snap_cnt_q  <= '0;
      snap_id_q   <= '0;
      frame_cnt_q <= 8'd0;
      bad_cnt_q   <= 8'd0;
      overrun_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_door_q  <= 3'd0;
      out_count_q <= 8'd0;
      out_id_q    <= 5'd0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      snap_cnt_q  <= snap_cnt_d;
      snap_id_q   <= snap_id_d;
      frame_cnt_q <= frame_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      overrun_q   <= overrun_d;
      out_valid_q <= out_valid_d;
      out_door_q  <= out_door_d;
      out_count_q <= out_count_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_door  = out_door_q;
  assign out_count = out_count_q;
  assign out_id    = out_id_q;
  assign out_last  = out_last_q;
  assign overrun   = overrun_q;
  assign bad_cnt   = bad_cnt_q;

endmodule
